// File: rtl/link_fifo_buffer.sv
// link_fifo_buffer: valid/ready FIFO decoupling one point-to-point link.
// Registered flags only; a pushed word is visible one cycle later.
//
// Ports:
//   clock, reset      positive-edge clock, async active-high reset
//   input_valid/_ready/_data     producer side handshake and word
//   output_valid/_ready/_data    consumer side handshake and head word
//   occupancy         words stored, 0..DEPTH
//   quiescent         buffer empty, feeds the system halt condition
module link_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [DATA_WIDTH-1:0]   input_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [DATA_WIDTH-1:0]   output_data,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    quiescent
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic push;
  logic pop;

  // Handshake flags come from the count register only, so
  // neither side sees a combinational path from the other.
  assign input_ready  = (count_q != FULL);
  assign output_valid = (count_q != '0);
  assign quiescent    = (count_q == '0);
  assign occupancy    = count_q;

  assign push = input_valid & input_ready;
  assign pop  = output_valid & output_ready;

  assign output_data = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap
  // naturally at their bit width.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; stale entries are never
  // visible because output_valid gates them.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= input_data;
    end
  end

endmodule

// File: tb/tb_link_fifo_buffer.sv
// tb_link_fifo_buffer: scoreboard bench for link_fifo_buffer.
// Reference model is an ordered queue of accepted words.
module tb_link_fifo_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          input_valid;
  logic          input_ready;
  logic [DW-1:0] input_data;
  logic          output_valid;
  logic          output_ready;
  logic [DW-1:0] output_data;
  logic [CW-1:0] occupancy;
  logic          quiescent;

  link_fifo_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .input_data(input_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_data(output_data),
    .occupancy(occupancy),
    .quiescent(quiescent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] exp_q [$];
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int max_occ = 0;
  int mode = 0;
  logic [DW-1:0] last_out;
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  int            mon_n;
  logic [DW-1:0] mon_exp;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  // Consumer: 0 stall, 1 always ready, 2 random, 3 manual.
  always @(posedge clock) begin
    #1;
    if (mode == 0) output_ready = 1'b0;
    else if (mode == 1) output_ready = 1'b1;
    else if (mode == 2) output_ready = 1'($urandom_range(1, 0));
  end

  // Monitor: status flags against model size, pops against queue.
  always @(negedge clock) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      mon_n = exp_q.size();
      chk("occupancy", 64'(occupancy), 64'(mon_n));
      chk("output_valid", 64'(output_valid), 64'(mon_n != 0));
      chk("input_ready", 64'(input_ready), 64'(mon_n != DEPTH));
      chk("quiescent", 64'(quiescent), 64'(mon_n == 0));
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (hold_v && output_valid)
        chk("hold_stable", 64'(output_data), 64'(hold_d));
      hold_v = output_valid && !output_ready;
      hold_d = output_data;
      if (output_valid && output_ready) begin
        if (mon_n == 0) begin
          chk("pop_empty", 64'(output_valid), 64'(0));
        end else begin
          mon_exp = exp_q.pop_front();
          chk("data", 64'(output_data), 64'(mon_exp));
          last_out = output_data;
          pops++;
        end
      end
    end
  end

  // Present a word and hold it until accepted; the model
  // records it at the edge where it is taken.
  task automatic push_word(input logic [DW-1:0] d);
    int w;
    bit done;
    w = 0;
    done = 0;
    input_valid = 1'b1;
    input_data = d;
    while (!done) begin
      @(negedge clock);
      if (input_ready) begin
        @(posedge clock);
        exp_q.push_back(d);
        #1;
        input_valid = 1'b0;
        done = 1;
      end else begin
        @(posedge clock);
        #1;
        w++;
        if (w > 2000) begin
          chk("push_timeout", 64'(w), 64'(0));
          input_valid = 1'b0;
          done = 1;
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (k < budget && (exp_q.size() != 0)) begin
      @(posedge clock);
      k++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clock);
    #1;
  endtask

  int c0;
  int p0;

  initial begin
    reset = 1'b1;
    input_valid = 1'b0;
    input_data = '0;
    output_ready = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t1_ready", 64'(input_ready), 64'(1));
      chk("t1_valid", 64'(output_valid), 64'(0));
      chk("t1_occ", 64'(occupancy), 64'(0));
      chk("t1_quiet", 64'(quiescent), 64'(1));
    end
    @(posedge clock);
    #1;

    // 2: fill, refuse fifth word, drain in order
    mode = 0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) push_word(DW'(32'hA0 + i));
    input_valid = 1'b1;
    input_data = 32'hA4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t2_full_occ", 64'(occupancy), 64'(4));
      chk("t2_full_rdy", 64'(input_ready), 64'(0));
    end
    @(posedge clock);
    #1;
    mode = 1;
    p0 = pops;
    push_word(32'hA4);
    wait_drain(100);
    chk("t2_pops", 64'(pops - p0), 64'(5));
    chk("t2_last", 64'(last_out), 64'(32'hA4));

    // 3: streaming, one word per cycle
    mode = 1;
    repeat (3) @(posedge clock);
    #1;
    max_occ = 0;
    p0 = pops;
    c0 = cyc;
    for (int i = 0; i < 100; i++) push_word(DW'(i));
    chk("t3_cycles", 64'(cyc - c0), 64'(100));
    wait_drain(100);
    chk("t3_pops", 64'(pops - p0), 64'(100));
    chk("t3_maxocc", 64'(max_occ), 64'(1));

    // 4: full with push and pop at the same edge
    mode = 0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) push_word(DW'(32'hB0 + i));
    mode = 3;
    output_ready = 1'b1;
    input_valid = 1'b1;
    input_data = 32'hB4;
    @(negedge clock);
    chk("t4_full_rdy", 64'(input_ready), 64'(0));
    @(posedge clock);
    #1;
    output_ready = 1'b0;
    chk("t4_occ", 64'(occupancy), 64'(3));
    chk("t4_rdy", 64'(input_ready), 64'(1));
    push_word(32'hB4);
    chk("t4_refill", 64'(occupancy), 64'(4));
    mode = 1;
    wait_drain(100);
    chk("t4_last", 64'(last_out), 64'(32'hB4));

    // 5: async reset with two words stored
    mode = 0;
    repeat (2) @(posedge clock);
    #1;
    push_word(32'hC0);
    push_word(32'hC1);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", 64'(output_valid), 64'(0));
    chk("t5_occ", 64'(occupancy), 64'(0));
    chk("t5_quiet", 64'(quiescent), 64'(1));
    chk("t5_rdy", 64'(input_ready), 64'(1));
    exp_q.delete();
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    mode = 1;
    p0 = pops;
    push_word(32'h55);
    wait_drain(100);
    chk("t5_pops", 64'(pops - p0), 64'(1));
    chk("t5_first", 64'(last_out), 64'(32'h55));

    // 6: random valid/ready, 10k words
    mode = 2;
    p0 = pops;
    for (int i = 0; i < 10000; i++) begin
      while ($urandom_range(1, 0) == 1) begin
        @(posedge clock);
        #1;
      end
      push_word(DW'($urandom));
    end
    mode = 1;
    wait_drain(1000);
    chk("t6_pops", 64'(pops - p0), 64'(10000));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
